dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 16 +
 rtl/dmem_array.sv | 26 ++
 rtl/dmem_responder.sv | 115 +++++++++++
 tb/tb_dmem_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned DEPTH_DEF   = 64;
  localparam int unsigned LATENCY_DEF = 2;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, registered read (read-before-write).
// Contents are not reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write on request; always register the addressed word.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY
// cycles, then presents a registered response held until acknowledged.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              accept;
  logic              finish;
  logic              addr_err;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_rdata;

  assign accept   = (state_q == IDLE) && req_valid;
  assign finish   = (state_q == WAIT) && (cnt_q == '0);
  assign addr_err = (addr_q[1:0] != 2'b00) ||
                    ({2'b00, addr_q[ADDR_W-1:2]} >= ADDR_W'(DEPTH));
  // A reset arriving on the completing edge aborts the store.
  assign mem_we   = finish && we_q && !addr_err && reset;
  // The array read is registered, so it must be pointed at the incoming
  // address while idle; that way the word is ready even when LATENCY=1.
  assign mem_idx  = (state_q == IDLE) ? req_addr[IDX_W+1:2] : addr_q[IDX_W+1:2];

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk_i   (clk),
    .we_i    (mem_we),
    .addr_i  (mem_idx),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Response registers, updated only on the WAIT-to-RESP edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (finish) begin
      err_q   <= addr_err;
      rdata_q <= (we_q || addr_err) ? '0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=64, LATENCY=2).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full transaction with rsp_ready held high; lat counts negedge
  // samples after the acceptance edge until rsp_valid is seen.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] r, output logic e, output int l);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    l = 0;
    do begin @(negedge clk); l++; end while (!rsp_valid && l < 20);
    if (!rsp_valid) check("rsp_valid_timeout", 32'd0, 32'd1);
    r = rsp_rdata;
    e = rsp_err;
    @(posedge clk); #1;
  endtask

  logic [31:0] b2b_addr [4];
  logic [31:0] b2b_data [4];
  logic        b2b_we   [4];
  int          acc_cyc  [4];
  int          rsp_cyc  [4];
  logic [31:0] rsp_d    [4];
  logic        rsp_e    [4];

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int na, nr, n;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err",   32'(rsp_err), 32'd0);

    // Store then load, with latency check
    do_req(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("st10_err", 32'(er), 32'd0);
    check("st10_rdata", rd, 32'd0);
    check("st10_lat", 32'(lat), 32'd3);
    do_req(1'b0, 32'h10, 32'h0, rd, er, lat);
    check("ld10_rdata", rd, 32'hDEADBEEF);
    check("ld10_err", 32'(er), 32'd0);
    check("ld10_lat", 32'(lat), 32'd3);

    // Misaligned
    do_req(1'b1, 32'h12, 32'h55555555, rd, er, lat);
    check("st12_err", 32'(er), 32'd1);
    check("st12_rdata", rd, 32'd0);
    do_req(1'b0, 32'h10, 32'h0, rd, er, lat);
    check("ld10_after_mis", rd, 32'hDEADBEEF);
    do_req(1'b0, 32'h12, 32'h0, rd, er, lat);
    check("ld12_err", 32'(er), 32'd1);
    check("ld12_rdata", rd, 32'd0);

    // Out of range and top word
    do_req(1'b1, 32'hFC, 32'hCAFEF00D, rd, er, lat);
    check("stFC_err", 32'(er), 32'd0);
    do_req(1'b0, 32'h100, 32'h0, rd, er, lat);
    check("ld100_err", 32'(er), 32'd1);
    check("ld100_rdata", rd, 32'd0);
    do_req(1'b0, 32'h1010, 32'h0, rd, er, lat);
    check("ld1010_nowrap_err", 32'(er), 32'd1);
    check("ld1010_rdata", rd, 32'd0);
    do_req(1'b1, 32'h1010, 32'hBADBAD00, rd, er, lat);
    check("st1010_err", 32'(er), 32'd1);
    do_req(1'b0, 32'hFC, 32'h0, rd, er, lat);
    check("ldFC_err", 32'(er), 32'd0);
    check("ldFC_rdata", rd, 32'hCAFEF00D);
    do_req(1'b0, 32'h10, 32'h0, rd, er, lat);
    check("ld10_after_oor_st", rd, 32'hDEADBEEF);

    // Backpressure
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    check("bp_valid_seen", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid_hold", 32'(rsp_valid), 32'd1);
      check("bp_rdata_hold", rsp_rdata, 32'hDEADBEEF);
      check("bp_err_hold", 32'(rsp_err), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    check("bp_idle_valid", 32'(rsp_valid), 32'd0);

    // Reset during WAIT aborts the store
    do_req(1'b1, 32'h20, 32'h11111111, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(req_ready), 32'd1);
    check("midrst_valid", 32'(rsp_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    do_req(1'b0, 32'h20, 32'h0, rd, er, lat);
    check("midrst_old_value", rd, 32'h11111111);

    // Back-to-back with req_valid held high
    b2b_we[0] = 1'b1; b2b_addr[0] = 32'h30; b2b_data[0] = 32'hA5A5A5A5;
    b2b_we[1] = 1'b1; b2b_addr[1] = 32'h34; b2b_data[1] = 32'h0BADF00D;
    b2b_we[2] = 1'b0; b2b_addr[2] = 32'h30; b2b_data[2] = 32'h0;
    b2b_we[3] = 1'b0; b2b_addr[3] = 32'h34; b2b_data[3] = 32'h0;
    na = 0; nr = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = b2b_we[0]; req_addr = b2b_addr[0]; req_wdata = b2b_data[0];
    for (int c = 0; c < 80 && nr < 4; c++) begin
      logic acc;
      if (c > 0) @(negedge clk);
      acc = 1'b0;
      if (rsp_valid) begin
        rsp_cyc[nr] = cyc + 1; rsp_d[nr] = rsp_rdata; rsp_e[nr] = rsp_err; nr++;
      end
      if (req_ready && na < 4) begin
        acc_cyc[na] = cyc + 1; na++; acc = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (na < 4) begin
          req_we = b2b_we[na]; req_addr = b2b_addr[na]; req_wdata = b2b_data[na];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    check("b2b_accepts", 32'(na), 32'd4);
    check("b2b_responses", 32'(nr), 32'd4);
    if (na == 4 && nr == 4) begin
      for (int k = 0; k < 4; k++)
        check("b2b_hs_latency", 32'(rsp_cyc[k] - acc_cyc[k]), 32'd3);
      for (int k = 1; k < 4; k++)
        check("b2b_accept_after_hs", 32'(acc_cyc[k] - rsp_cyc[k-1]), 32'd1);
      check("b2b_ld30", rsp_d[2], 32'hA5A5A5A5);
      check("b2b_ld34", rsp_d[3], 32'h0BADF00D);
      check("b2b_ld_err", 32'({rsp_e[2], rsp_e[3]}), 32'd0);
    end
    repeat (4) @(negedge clk);
    check("b2b_no_extra_rsp", 32'(rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
